// File: rtl/adder_serial_n_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
// Shared definitions for the serial adder/subtractor:
//   state_e          - FSM state encoding (IDLE, RUN, DONE)
//   cnt_width()      - chunk-counter width, $clog2(nchunk) but never below 1
// -----------------------------------------------------------------------------
package adder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // A single-chunk configuration still needs a 1-bit counter.
   function automatic int cnt_width(input int nchunk);
      return (nchunk <= 1) ? 1 : $clog2(nchunk);
   endfunction

endpackage

// File: rtl/adder_serial_n_if.sv
// -----------------------------------------------------------------------------
// adder_serial_n_if
// Request/result bundle of the serial adder.
//   master : drives start_in, sub_in, a_in, b_in, c_in; observes results
//   slave  : the adder itself; drives busy_out, done_out, sum_out,
//            carry_out, overflow_out
// -----------------------------------------------------------------------------
interface adder_serial_n_if #(
   parameter int WIDTH = 16
);
   logic             start_in;
   logic             sub_in;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             c_in;
   logic             busy_out;
   logic             done_out;
   logic [WIDTH-1:0] sum_out;
   logic             carry_out;
   logic             overflow_out;

   modport master (
      output start_in, sub_in, a_in, b_in, c_in,
      input  busy_out, done_out, sum_out, carry_out, overflow_out
   );

   modport slave (
      input  start_in, sub_in, a_in, b_in, c_in,
      output busy_out, done_out, sum_out, carry_out, overflow_out
   );
endinterface

// File: rtl/adder_serial_n_ripple.sv
// -----------------------------------------------------------------------------
// full_adder / ripple_adder_n
// full_adder     : single-bit cell; a_in, b_in, c_in -> sum_out, carry_out
// ripple_adder_n : N-bit ripple chain of full_adder cells
//   a_in[N], b_in[N], c_in  operands and carry-in
//   sum_out[N], carry_out   N-bit sum and carry out of bit N-1
//   msb_carry_out           carry into bit N-1 (for signed overflow)
// -----------------------------------------------------------------------------
module full_adder (
   input  logic a_in,
   input  logic b_in,
   input  logic c_in,
   output logic sum_out,
   output logic carry_out
);
   assign sum_out   = a_in ^ b_in ^ c_in;
   assign carry_out = (a_in & b_in) | (c_in & (a_in ^ b_in));
endmodule

module ripple_adder_n #(
   parameter int N = 4
) (
   input  logic [N-1:0] a_in,
   input  logic [N-1:0] b_in,
   input  logic         c_in,
   output logic [N-1:0] sum_out,
   output logic         carry_out,
   output logic         msb_carry_out
);
   // c_s[i] is the carry into bit i; c_s[N] leaves the slice.
   logic [N:0] c_s;

   assign c_s[0] = c_in;

   for (genvar i = 0; i < N; i++) begin : g_bit
      full_adder u_fa (
         .a_in      (a_in[i]),
         .b_in      (b_in[i]),
         .c_in      (c_s[i]),
         .sum_out   (sum_out[i]),
         .carry_out (c_s[i+1])
      );
   end

   assign carry_out     = c_s[N];
   assign msb_carry_out = c_s[N-1];
endmodule

// File: rtl/adder_serial_n.sv
// -----------------------------------------------------------------------------
// adder_serial_n
// Multi-cycle adder/subtractor: CHUNK bits per clock, LS chunk first.
//   clk_in  : clock, rising edge
//   rst_in  : synchronous active-high reset
//   bus     : adder_serial_n_if.slave (start/sub/a/b/c in,
//             busy/done/sum/carry/overflow out)
// Start is accepted in IDLE or DONE; results update only on entry to DONE.
// -----------------------------------------------------------------------------
module adder_serial_n
   import adder_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk_in,
   input  logic             rst_in,
   adder_serial_n_if.slave  bus
);
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CW     = cnt_width(NCHUNK);
   localparam logic [CW-1:0] LAST_CNT = CW'(NCHUNK - 1);

   if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
      $error("adder_serial_n: WIDTH must be a multiple of CHUNK");
   end
   if ((CHUNK < 1) || (CHUNK > WIDTH)) begin : g_bad_range
      $error("adder_serial_n: CHUNK must lie in 1..WIDTH");
   end

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] work_q, work_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic [CHUNK-1:0]       slice_sum_s;
   logic                   slice_cout_s;
   logic                   slice_msb_s;
   logic [WIDTH+CHUNK-1:0] work_cat_s;
   logic [WIDTH-1:0]       work_shift_s;

   ripple_adder_n #(.N(CHUNK)) u_slice (
      .a_in          (a_q[CHUNK-1:0]),
      .b_in          (b_q[CHUNK-1:0]),
      .c_in          (carry_q),
      .sum_out       (slice_sum_s),
      .carry_out     (slice_cout_s),
      .msb_carry_out (slice_msb_s)
   );

   // New chunk enters at the top; written as a concatenate-and-drop so that
   // CHUNK == WIDTH needs no special case.
   assign work_cat_s   = {slice_sum_s, work_q};
   assign work_shift_s = work_cat_s[WIDTH+CHUNK-1:CHUNK];

   // Next-state, datapath and result-register update logic.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      work_d  = work_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (bus.start_in) begin
               a_d = bus.a_in;
               // Subtraction is a + ~b + 1; the add-mode carry-in is ignored.
               if (bus.sub_in) begin
                  b_d     = ~bus.b_in;
                  carry_d = 1'b1;
               end else begin
                  b_d     = bus.b_in;
                  carry_d = bus.c_in;
               end
               work_d  = {WIDTH{1'b0}};
               cnt_d   = {CW{1'b0}};
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            a_d     = a_q >> CHUNK;
            b_d     = b_q >> CHUNK;
            carry_d = slice_cout_s;
            work_d  = work_shift_s;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == LAST_CNT) begin
               // Last slice holds bit WIDTH-1, so its carries give overflow.
               state_d = ST_DONE;
               sum_d   = work_shift_s;
               cout_d  = slice_cout_s;
               ovf_d   = slice_cout_s ^ slice_msb_s;
            end else begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, working and result registers with synchronous reset.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q <= ST_IDLE;
         a_q     <= {WIDTH{1'b0}};
         b_q     <= {WIDTH{1'b0}};
         carry_q <= 1'b0;
         work_q  <= {WIDTH{1'b0}};
         cnt_q   <= {CW{1'b0}};
         sum_q   <= {WIDTH{1'b0}};
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         work_q  <= work_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.busy_out     = (state_q == ST_RUN);
   assign bus.done_out     = (state_q == ST_DONE);
   assign bus.sum_out      = sum_q;
   assign bus.carry_out    = cout_q;
   assign bus.overflow_out = ovf_q;

endmodule

// File: tb/tb_adder_serial_n.sv
// -----------------------------------------------------------------------------
// tb_adder_serial_n
// Directed tests on a 16/4 instance plus a lockstep random regression over
// (16,4), (16,16), (12,3) and (8,1). Expected results are queued when an
// operation is started and compared when done_out is seen.
// -----------------------------------------------------------------------------
module tb_adder_serial_n;

   logic clk;
   logic rst;

   adder_serial_n_if #(.WIDTH(16)) if0 ();
   adder_serial_n_if #(.WIDTH(16)) if1 ();
   adder_serial_n_if #(.WIDTH(12)) if2 ();
   adder_serial_n_if #(.WIDTH(8))  if3 ();

   adder_serial_n #(.WIDTH(16), .CHUNK(4))  u_dut0 (.clk_in(clk), .rst_in(rst), .bus(if0.slave));
   adder_serial_n #(.WIDTH(16), .CHUNK(16)) u_dut1 (.clk_in(clk), .rst_in(rst), .bus(if1.slave));
   adder_serial_n #(.WIDTH(12), .CHUNK(3))  u_dut2 (.clk_in(clk), .rst_in(rst), .bus(if2.slave));
   adder_serial_n #(.WIDTH(8),  .CHUNK(1))  u_dut3 (.clk_in(clk), .rst_in(rst), .bus(if3.slave));

   int n_checks = 0;
   int n_errors = 0;

   // Expected {overflow, carry, sum[15:0]} per instance.
   logic [17:0] q0[$];
   logic [17:0] q1[$];
   logic [17:0] q2[$];
   logic [17:0] q3[$];
   logic [17:0] e0, e1, e2, e3;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference arithmetic: carry as "no borrow" for subtract, overflow from signs.
   function automatic logic [17:0] model(input int w, input logic sub, input logic [15:0] a,
                                         input logic [15:0] b, input logic c);
      longint unsigned mask, ua, ub, s;
      logic cy, ov, sa, sb, ss;
      mask = (64'd1 << w) - 64'd1;
      ua   = {48'd0, a} & mask;
      ub   = {48'd0, b} & mask;
      if (sub) begin
         s  = (ua - ub) & mask;
         cy = (ua >= ub);
      end else begin
         s  = ua + ub + {63'd0, c};
         cy = s[w];
         s  = s & mask;
      end
      sa = ua[w-1];
      sb = ub[w-1];
      ss = s[w-1];
      ov = sub ? ((sa != sb) && (ss != sa)) : ((sa == sb) && (ss != sa));
      return {ov, cy, s[15:0]};
   endfunction

   // Result monitors: every done pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (if0.done_out) begin
         if (q0.size() == 0) check_val("dut0_spurious_done", 32'd1, 32'd0);
         else begin
            e0 = q0.pop_front();
            check_val("dut0_result", {14'd0, if0.overflow_out, if0.carry_out, if0.sum_out}, {14'd0, e0});
         end
      end
      if (if1.done_out) begin
         if (q1.size() == 0) check_val("dut1_spurious_done", 32'd1, 32'd0);
         else begin
            e1 = q1.pop_front();
            check_val("dut1_result", {14'd0, if1.overflow_out, if1.carry_out, if1.sum_out}, {14'd0, e1});
         end
      end
      if (if2.done_out) begin
         if (q2.size() == 0) check_val("dut2_spurious_done", 32'd1, 32'd0);
         else begin
            e2 = q2.pop_front();
            check_val("dut2_result", {14'd0, if2.overflow_out, if2.carry_out, 4'd0, if2.sum_out}, {14'd0, e2});
         end
      end
      if (if3.done_out) begin
         if (q3.size() == 0) check_val("dut3_spurious_done", 32'd1, 32'd0);
         else begin
            e3 = q3.pop_front();
            check_val("dut3_result", {14'd0, if3.overflow_out, if3.carry_out, 8'd0, if3.sum_out}, {14'd0, e3});
         end
      end
   end

   task automatic drain(input int max_cycles);
      int i;
      i = 0;
      while (((q0.size() + q1.size() + q2.size() + q3.size()) != 0) && (i < max_cycles)) begin
         @(posedge clk); #1;
         i++;
      end
      check_val("drain_timeout", 32'(q0.size() + q1.size() + q2.size() + q3.size()), 32'd0);
   endtask

   task automatic drive0(input logic sub, input logic [15:0] a, input logic [15:0] b, input logic c);
      if0.sub_in = sub;
      if0.a_in   = a;
      if0.b_in   = b;
      if0.c_in   = c;
   endtask

   // One operation on the 16/4 instance with a literal expectation.
   task automatic op0(input logic sub, input logic [15:0] a, input logic [15:0] b,
                      input logic c, input logic [17:0] exp);
      drive0(sub, a, b, c);
      if0.start_in = 1'b1;
      q0.push_back(exp);
      @(posedge clk); #1;
      if0.start_in = 1'b0;
      drain(20);
   endtask

   // Same random operation to all four instances.
   task automatic rand_op_all();
      logic [15:0] a, b;
      logic sub, c;
      a   = 16'($urandom);
      b   = 16'($urandom);
      sub = 1'($urandom);
      c   = 1'($urandom);
      if0.a_in = a;        if0.b_in = b;        if0.sub_in = sub; if0.c_in = c;
      if1.a_in = a;        if1.b_in = b;        if1.sub_in = sub; if1.c_in = c;
      if2.a_in = a[11:0];  if2.b_in = b[11:0];  if2.sub_in = sub; if2.c_in = c;
      if3.a_in = a[7:0];   if3.b_in = b[7:0];   if3.sub_in = sub; if3.c_in = c;
      q0.push_back(model(16, sub, a, b, c));
      q1.push_back(model(16, sub, a, b, c));
      q2.push_back(model(12, sub, a, b, c));
      q3.push_back(model(8,  sub, a, b, c));
      if0.start_in = 1'b1; if1.start_in = 1'b1; if2.start_in = 1'b1; if3.start_in = 1'b1;
      @(posedge clk); #1;
      if0.start_in = 1'b0; if1.start_in = 1'b0; if2.start_in = 1'b0; if3.start_in = 1'b0;
      drain(30);
   endtask

   logic [15:0] bb_a[4];
   logic [15:0] bb_b[4];
   logic        bb_sub[4];
   logic        bb_c[4];
   logic [17:0] bb_exp[4];

   initial begin
      rst = 1'b1;
      if0.start_in = 1'b0; if0.sub_in = 1'b0; if0.a_in = 16'd0; if0.b_in = 16'd0; if0.c_in = 1'b0;
      if1.start_in = 1'b0; if1.sub_in = 1'b0; if1.a_in = 16'd0; if1.b_in = 16'd0; if1.c_in = 1'b0;
      if2.start_in = 1'b0; if2.sub_in = 1'b0; if2.a_in = 12'd0; if2.b_in = 12'd0; if2.c_in = 1'b0;
      if3.start_in = 1'b0; if3.sub_in = 1'b0; if3.a_in = 8'd0;  if3.b_in = 8'd0;  if3.c_in = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state
      check_val("rst_busy",  32'(if0.busy_out), 32'd0);
      check_val("rst_done",  32'(if0.done_out), 32'd0);
      check_val("rst_sum",   32'(if0.sum_out),  32'd0);
      check_val("rst_carry", 32'(if0.carry_out), 32'd0);
      check_val("rst_ovf",   32'(if0.overflow_out), 32'd0);

      // 0x1234 + 0x4321 with latency: busy for 4 cycles after E0, then done.
      drive0(1'b0, 16'h1234, 16'h4321, 1'b0);
      if0.start_in = 1'b1;
      q0.push_back({1'b0, 1'b0, 16'h5555});
      @(posedge clk); #1;
      if0.start_in = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check_val("lat_busy", 32'(if0.busy_out), 32'd1);
         check_val("lat_nodone", 32'(if0.done_out), 32'd0);
         @(posedge clk); #1;
      end
      check_val("lat_done", 32'(if0.done_out), 32'd1);
      check_val("lat_busy_low", 32'(if0.busy_out), 32'd0);
      drain(10);
      check_val("held_sum", 32'(if0.sum_out), 32'h5555);

      op0(1'b0, 16'hFFFF, 16'h0001, 1'b0, {1'b0, 1'b1, 16'h0000});
      op0(1'b0, 16'h7FFF, 16'h0001, 1'b0, {1'b1, 1'b0, 16'h8000});
      op0(1'b1, 16'h0005, 16'h0007, 1'b1, {1'b0, 1'b0, 16'hFFFE});
      op0(1'b1, 16'h8000, 16'h0001, 1'b0, {1'b1, 1'b1, 16'h7FFF});

      // Reset sampled during the second RUN cycle discards the operation.
      drive0(1'b0, 16'h1111, 16'h2222, 1'b0);
      if0.start_in = 1'b1;
      @(posedge clk); #1;
      if0.start_in = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_val("midrst_busy",  32'(if0.busy_out), 32'd0);
      check_val("midrst_done",  32'(if0.done_out), 32'd0);
      check_val("midrst_sum",   32'(if0.sum_out),  32'd0);
      check_val("midrst_carry", 32'(if0.carry_out), 32'd0);
      check_val("midrst_ovf",   32'(if0.overflow_out), 32'd0);
      repeat (8) @(posedge clk);
      #1;

      // Start while busy is ignored.
      drive0(1'b0, 16'h1111, 16'h2222, 1'b0);
      if0.start_in = 1'b1;
      q0.push_back({1'b0, 1'b0, 16'h3333});
      @(posedge clk); #1;
      if0.start_in = 1'b0;
      @(posedge clk); #1;
      check_val("ign_busy", 32'(if0.busy_out), 32'd1);
      drive0(1'b0, 16'hAAAA, 16'h5555, 1'b1);
      if0.start_in = 1'b1;
      @(posedge clk); #1;
      if0.start_in = 1'b0;
      drain(20);
      repeat (8) @(posedge clk);
      #1;
      check_val("ign_sum", 32'(if0.sum_out), 32'h3333);

      // Start held high: a new operation accepted every 5 cycles.
      bb_sub[0] = 1'b0; bb_a[0] = 16'h0001; bb_b[0] = 16'h0002; bb_c[0] = 1'b0; bb_exp[0] = {1'b0, 1'b0, 16'h0003};
      bb_sub[1] = 1'b1; bb_a[1] = 16'h0010; bb_b[1] = 16'h0001; bb_c[1] = 1'b0; bb_exp[1] = {1'b0, 1'b1, 16'h000F};
      bb_sub[2] = 1'b0; bb_a[2] = 16'h8000; bb_b[2] = 16'h8000; bb_c[2] = 1'b1; bb_exp[2] = {1'b1, 1'b1, 16'h0001};
      bb_sub[3] = 1'b1; bb_a[3] = 16'h0000; bb_b[3] = 16'h0001; bb_c[3] = 1'b0; bb_exp[3] = {1'b0, 1'b0, 16'hFFFF};
      drive0(bb_sub[0], bb_a[0], bb_b[0], bb_c[0]);
      q0.push_back(bb_exp[0]);
      if0.start_in = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check_val("b2b_busy", 32'(if0.busy_out), 32'd1);
         repeat (4) @(posedge clk);
         #1;
         check_val("b2b_done", 32'(if0.done_out), 32'd1);
         if (i < 3) begin
            drive0(bb_sub[i+1], bb_a[i+1], bb_b[i+1], bb_c[i+1]);
            q0.push_back(bb_exp[i+1]);
         end else begin
            if0.start_in = 1'b0;
         end
      end
      drain(10);

      // Random regression across all four configurations.
      for (int n = 0; n < 40; n++) begin
         rand_op_all();
      end
      repeat (4) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
